// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port between two
// valid/ready requesters, throttled by the FIFO full/almost-full flags.
module fifo_wr_arbiter #(
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int BCW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          ready0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          ready1,
  input  logic          fifo_full,
  input  logic          fifo_afull,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_din,
  output logic          gnt_id,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);

  logic [1:0]     state, state_nxt;
  logic [BCW-1:0] beat_cnt, beat_nxt;
  logic           last_gnt, last_nxt, gnt_nxt;
  logic           stall, xfer0, xfer1, xfer;
  logic           cur_ch, cur_req, other_req, burst_end;
  logic           enter, new_ch;

  // A write already in flight will fill the last free slot, so almost-full
  // must stall as well when fifo_wr_en is high.
  assign stall  = fifo_full | (fifo_afull & fifo_wr_en);
  assign ready0 = (state == GNT0) & ~stall;
  assign ready1 = (state == GNT1) & ~stall;
  assign xfer0  = req0 & ready0;
  assign xfer1  = req1 & ready1;
  assign xfer   = xfer0 | xfer1;
  assign busy   = (state != IDLE);

  assign cur_ch    = (state == GNT1);
  assign cur_req   = cur_ch ? req1 : req0;
  assign other_req = cur_ch ? req0 : req1;
  assign burst_end = xfer & (beat_cnt == LAST_BEAT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    beat_nxt  = beat_cnt;
    last_nxt  = last_gnt;
    gnt_nxt   = gnt_id;
    enter     = 1'b0;
    new_ch    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          enter  = 1'b1;
          new_ch = (req0 & req1) ? ~last_gnt : req1;
        end
      end
      GNT0, GNT1: begin
        if (!cur_req || burst_end) begin
          // Release: hand over to the other channel first, else restart our
          // own burst, else go idle.
          if (other_req) begin
            enter  = 1'b1;
            new_ch = ~cur_ch;
          end else if (cur_req) begin
            enter  = 1'b1;
            new_ch = cur_ch;
          end else begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end
        end else begin
          beat_nxt = beat_cnt + BCW'(xfer);
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
    if (enter) begin
      state_nxt = new_ch ? GNT1 : GNT0;
      beat_nxt  = '0;
      last_nxt  = new_ch;
      gnt_nxt   = new_ch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_gnt   <= 1'b1;
      gnt_id     <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state      <= state_nxt;
      beat_cnt   <= beat_nxt;
      last_gnt   <= last_nxt;
      gnt_id     <= gnt_nxt;
      fifo_wr_en <= xfer;
      if (xfer0)      fifo_din <= din0;
      else if (xfer1) fifo_din <= din1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a directed vector table plus
// hand-written multi-cycle sequences against a small FIFO occupancy model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          ready0, ready1;
  logic          fifo_full, fifo_afull;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          gnt_id, busy;

  // FIFO model controls: the table drives flags directly, sequences use the model
  logic use_model = 1'b0, tfull = 1'b0, tafull = 1'b0, rd = 1'b0, mdl_clr = 1'b0;
  int   cnt = 0, wr_n = 0, overflow = 0;
  logic [7:0] wr_log [0:1023];
  int   acc_cyc0 [0:31];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(DW), .BURST(4), .BCW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .din0       (din0),
    .ready0     (ready0),
    .req1       (req1),
    .din1       (din1),
    .ready1     (ready1),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .gnt_id     (gnt_id),
    .busy       (busy)
  );

  assign fifo_full  = use_model ? (cnt == 16) : tfull;
  assign fifo_afull = use_model ? (cnt == 15) : tafull;

  always @(posedge clk) begin
    if (fifo_wr_en) begin
      wr_log[wr_n] <= fifo_din;
      wr_n         <= wr_n + 1;
    end
    if (mdl_clr) cnt <= 0;
    else begin
      if (fifo_wr_en && cnt == 16) overflow <= overflow + 1;
      cnt <= cnt + ((fifo_wr_en && cnt < 16) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
    end
  end

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       full, afull;
    logic       er0, er1, ewe;
    logic [7:0] edin;
    logic       egnt, ebusy;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic r0, logic r1, logic [7:0] d0, logic [7:0] d1,
                              logic full, logic afull, logic er0, logic er1,
                              logic ewe, logic [7:0] edin, logic egnt, logic ebusy);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.full = full; v.afull = afull;
    v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.edin = edin; v.egnt = egnt; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Must be called just after a negedge; returns at a negedge with the
  // request lines left at their last driven values.
  task automatic stream(input logic [7:0] b0, input int n0, input logic [7:0] b1,
                        input int n1, input int budget, output int i0, output int i1);
    int   c;
    logic a0, a1;
    i0 = 0; i1 = 0; c = 0;
    while ((i0 < n0 || i1 < n1) && c < budget) begin
      req0 = (i0 < n0); din0 = b0 + 8'(i0);
      req1 = (i1 < n1); din1 = b1 + 8'(i1);
      #1;
      a0 = req0 & ready0;
      a1 = req1 & ready1;
      if (a0 && i0 < 32) acc_cyc0[i0] = c;
      @(posedge clk);
      if (a0) i0++;
      if (a1) i1++;
      c++;
      @(negedge clk);
    end
  endtask

  task automatic reset_all();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rd = 1'b0;
    rst = 1'b0; mdl_clr = 1'b1;
    @(negedge clk);
    rst = 1'b1; mdl_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, a0, a1, b0, b1;
    logic [7:0] exp;

    tbl[0]  = mk(0, 0, 8'h00, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 8'hA0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(1, 0, 8'hA0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 1);
    tbl[3]  = mk(1, 1, 8'hA1, 8'hB0, 0, 0,  1, 0, 1, 8'hA0, 0, 1);
    tbl[4]  = mk(0, 1, 8'hA1, 8'hB0, 0, 0,  1, 0, 1, 8'hA1, 0, 1);
    tbl[5]  = mk(0, 1, 8'h00, 8'hB0, 0, 0,  0, 1, 0, 8'hA1, 1, 1);
    tbl[6]  = mk(0, 1, 8'h00, 8'hB1, 1, 0,  0, 0, 1, 8'hB0, 1, 1);
    tbl[7]  = mk(0, 1, 8'h00, 8'hB1, 0, 1,  0, 1, 0, 8'hB0, 1, 1);
    tbl[8]  = mk(0, 1, 8'h00, 8'hB2, 0, 1,  0, 0, 1, 8'hB1, 1, 1);
    tbl[9]  = mk(0, 1, 8'h00, 8'hB2, 0, 1,  0, 1, 0, 8'hB1, 1, 1);
    tbl[10] = mk(1, 1, 8'hA2, 8'hB3, 0, 0,  0, 1, 1, 8'hB2, 1, 1);
    tbl[11] = mk(1, 1, 8'hA2, 8'hB4, 0, 0,  1, 0, 1, 8'hB3, 0, 1);
    tbl[12] = mk(0, 0, 8'h00, 8'h00, 0, 0,  1, 0, 1, 8'hA2, 0, 1);
    tbl[13] = mk(0, 0, 8'h00, 8'h00, 0, 0,  0, 0, 0, 8'hA2, 0, 0);
    tbl[14] = mk(1, 1, 8'hA3, 8'hB4, 0, 0,  0, 0, 0, 8'hA2, 0, 0);
    tbl[15] = mk(1, 1, 8'hA3, 8'hB4, 0, 0,  0, 1, 0, 8'hA2, 1, 1);
    tbl[16] = mk(0, 0, 8'h00, 8'h00, 0, 0,  0, 1, 1, 8'hB4, 1, 1);
    tbl[17] = mk(0, 0, 8'h00, 8'h00, 0, 0,  0, 0, 0, 8'hB4, 1, 0);

    // T1: reset held with both channels requesting
    #1 rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); #1;
    check("t1.ready0", ready0, 0);
    check("t1.ready1", ready1, 0);
    check("t1.wr_en", fifo_wr_en, 0);
    check("t1.busy", busy, 0);
    check("t1.gnt_id", gnt_id, 0);
    check("t1.fifo_din", fifo_din, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t1.tie_gnt_id", gnt_id, 0);
    check("t1.tie_ready0", ready0, 1);
    check("t1.tie_ready1", ready1, 0);
    req0 = 1'b0; req1 = 1'b0;

    // Directed vector table: inputs for a cycle, expected outputs in that cycle
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req0 = tbl[i].r0; req1 = tbl[i].r1; din0 = tbl[i].d0; din1 = tbl[i].d1;
      tfull = tbl[i].full; tafull = tbl[i].afull;
      #1;
      check($sformatf("tbl%0d.ready0", i), ready0, tbl[i].er0);
      check($sformatf("tbl%0d.ready1", i), ready1, tbl[i].er1);
      check($sformatf("tbl%0d.wr_en", i), fifo_wr_en, tbl[i].ewe);
      check($sformatf("tbl%0d.fifo_din", i), fifo_din, tbl[i].edin);
      check($sformatf("tbl%0d.gnt_id", i), gnt_id, tbl[i].egnt);
      check($sformatf("tbl%0d.busy", i), busy, tbl[i].ebusy);
    end
    req0 = 1'b0; req1 = 1'b0; tfull = 1'b0; tafull = 1'b0;
    use_model = 1'b1;

    // T2: single channel, 6 words spanning a burst boundary
    reset_all();
    base = wr_n;
    stream(8'h10, 6, 8'h00, 0, 40, a0, a1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("t2.accepted", a0, 6);
    check("t2.writes", wr_n - base, 6);
    for (int k = 0; k < 6; k++) check($sformatf("t2.word%0d", k), wr_log[base + k], 8'h10 + 8'(k));
    check("t2.no_gap_4_5", acc_cyc0[4] - acc_cyc0[3], 1);
    check("t2.back_to_back", acc_cyc0[5] - acc_cyc0[0], 5);

    // T3: contention, 8 words each, bursts alternate starting with ch0
    reset_all();
    base = wr_n;
    stream(8'h40, 8, 8'h80, 8, 80, a0, a1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("t3.writes", wr_n - base, 16);
    for (int k = 0; k < 16; k++) begin
      int bst, idx;
      bst = k / 4;
      idx = (bst / 2) * 4 + k % 4;
      exp = (bst % 2 == 0) ? 8'h40 + 8'(idx) : 8'h80 + 8'(idx);
      check($sformatf("t3.word%0d", k), wr_log[base + k], exp);
    end
    check("t3.overflow", overflow, 0);

    // T4: stream into an undrained FIFO, then free exactly one slot
    reset_all();
    base = wr_n;
    stream(8'h60, 20, 8'h00, 0, 60, a0, a1);
    #1;
    check("t4.accepted", a0, 16);
    check("t4.writes", wr_n - base, 16);
    check("t4.ready0_full", ready0, 0);
    check("t4.busy_full", busy, 1);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    stream(8'h60 + 8'(a0), 4, 8'h00, 0, 20, b0, b1);
    #1;
    check("t4.extra_accepted", b0, 1);
    check("t4.ready0_refull", ready0, 0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4.writes_total", wr_n - base, 17);
    check("t4.last_word", wr_log[base + 16], 8'h70);
    check("t4.overflow", overflow, 0);

    // T5: ch1 drops after two beats while ch0 waits
    reset_all();
    base = wr_n;
    req1 = 1'b1; din1 = 8'h90;
    #1 check("t5.idle_ready1", ready1, 0);
    @(negedge clk); #1;
    check("t5.gnt1_ready1", ready1, 1);
    check("t5.gnt1_id", gnt_id, 1);
    @(negedge clk);
    din1 = 8'h91;
    #1 check("t5.beat2_ready1", ready1, 1);
    @(negedge clk);
    req1 = 1'b0; req0 = 1'b1; din0 = 8'h20;
    #1;
    check("t5.drop_ready0", ready0, 0);
    check("t5.drop_ready1", ready1, 1);
    @(negedge clk); #1;
    check("t5.after_gnt_id", gnt_id, 0);
    check("t5.after_ready0", ready0, 1);
    check("t5.after_ready1", ready1, 0);
    check("t5.after_wr_en", fifo_wr_en, 0);
    @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("t5.writes", wr_n - base, 3);
    check("t5.word2", wr_log[base + 2], 8'h20);

    // T6: asynchronous reset between edges in the middle of a burst
    reset_all();
    req0 = 1'b1; din0 = 8'h55;
    @(negedge clk);
    @(negedge clk); #1;
    check("t6.wr_en_before", fifo_wr_en, 1);
    #2 rst = 1'b0;
    #1;
    check("t6.wr_en_async", fifo_wr_en, 0);
    check("t6.busy_async", busy, 0);
    check("t6.ready0_async", ready0, 0);
    check("t6.gnt_id_async", gnt_id, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("t6.ready0_idle", ready0, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
